// File: rtl/alu_seq.sv
// Issue/writeback sequencer for the combinational ALU.
// Optional sticky saturation flag: ALU_SEQ_SAT_FLAG_EN.
module alu_seq #(
  parameter int N = 16,
  parameter int C = 6,
  parameter int S = 5,
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  output logic [C-1:0] alu_opcode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [S-1:0] alu_shift,
  input  logic [N-1:0] alu_y,
  input  logic [R-1:0] rd_addr,
  output logic [N-1:0] rd_data,
  output logic         busy,
  output logic         err,
`ifdef ALU_SEQ_SAT_FLAG_EN
  output logic         sat,
`endif
  input  logic         err_clr
);

  localparam logic [C-1:0] OP_NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEC,
    ST_EXE,
    ST_WB
  } st_t;

  st_t          r_st;
  st_t          w_nxt;
  logic         r_live;
  logic [31:0]  r_ins;
  logic [N-1:0] r_rf [2**R];

  logic [C-1:0] w_op;
  logic [S-1:0] w_sh;
  logic [R-1:0] w_rd;
  logic [R-1:0] w_ra;
  logic [R-1:0] w_rb;
  logic [12:0]  w_imm13;
  logic [N-1:0] w_sext;
  logic         w_legal;
  logic         w_isimm;
  logic         w_we;
  logic         w_acc;

  assign w_op    = r_ins[31:26];
  assign w_sh    = r_ins[25:21];
  assign w_rd    = r_ins[20:17];
  assign w_ra    = r_ins[16:13];
  assign w_rb    = r_ins[12:9];
  assign w_imm13 = r_ins[12:0];
  assign w_sext  = {{(N-13){w_imm13[12]}}, w_imm13};

  assign w_legal = (w_op <= 6'd12)
                 || (w_op >= 6'd15 && w_op <= 6'd26);
  assign w_we    = (r_st == ST_WB) && w_legal
                 && (w_op != OP_NOP) && (w_rd != '0);

  assign in_ready = r_live && (r_st == ST_IDLE);
  assign busy     = (r_st != ST_IDLE);
  assign w_acc    = in_valid && in_ready;

  // Immediate-form opcodes take B from imm13
  always_comb begin
    w_isimm = 1'b0;
    unique case (w_op)
      6'd2, 6'd4, 6'd6, 6'd8, 6'd10,
      6'd12, 6'd16, 6'd18, 6'd20: w_isimm = 1'b1;
      default:                    w_isimm = 1'b0;
    endcase
  end

  // State register; r_live keeps in_ready low until the first edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= ST_IDLE;
      r_live <= 1'b0;
    end else begin
      r_st   <= w_nxt;
      r_live <= 1'b1;
    end
  end

  // Fixed four-state walk per instruction
  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      ST_IDLE: if (w_acc) w_nxt = ST_DEC;
      ST_DEC:  w_nxt = ST_EXE;
      ST_EXE:  w_nxt = ST_WB;
      ST_WB:   w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch and registered ALU drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins      <= '0;
      alu_opcode <= OP_NOP;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_shift  <= '0;
    end else begin
      if (w_acc)
        r_ins <= in_instr;
      if (r_st == ST_DEC) begin
        alu_opcode <= w_op;
        alu_a      <= r_rf[w_ra];
        alu_b      <= w_isimm ? w_sext : r_rf[w_rb];
        alu_shift  <= w_sh;
      end
      if (r_st == ST_WB)
        alu_opcode <= OP_NOP;
    end
  end

  // Register file writeback and registered host read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**R; i++)
        r_rf[i] <= '0;
      rd_data <= '0;
    end else begin
      if (w_we)
        r_rf[w_rd] <= alu_y;
      rd_data <= r_rf[rd_addr];
    end
  end

  // Sticky illegal-opcode flag; set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (r_st == ST_WB && !w_legal)
      err <= 1'b1;
    else if (err_clr)
      err <= 1'b0;
  end

`ifdef ALU_SEQ_SAT_FLAG_EN
  logic w_sat_set;
  assign w_sat_set = w_we
                   && (w_op >= 6'd1) && (w_op <= 6'd12)
                   && (alu_y == 16'h7FFF || alu_y == 16'hFFFF);

  // Sticky saturation flag; set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat <= 1'b0;
    else if (w_sat_set)
      sat <= 1'b1;
    else if (err_clr)
      sat <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq.
// Stub ALU: Y = A+B for ADD_I, else A^B.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_shift;
  logic [15:0] alu_y;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        err;
  logic        err_clr;
`ifdef ALU_SEQ_SAT_FLAG_EN
  logic        sat;
`endif

  int n_chk;
  int n_err;

  alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_shift  (alu_shift),
    .alu_y      (alu_y),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .err        (err),
`ifdef ALU_SEQ_SAT_FLAG_EN
    .sat        (sat),
`endif
    .err_clr    (err_clr)
  );

  assign alu_y = (alu_opcode == 6'd2) ? alu_a + alu_b
                                      : alu_a ^ alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [3:0] rd,
                                     input logic [3:0] ra,
                                     input logic [12:0] imm);
    return {op, 5'd0, rd, ra, imm};
  endfunction

  task automatic rdreg(input logic [3:0] a,
                       output logic [15:0] v);
    rd_addr = a;
    tick;
    v = rd_data;
  endtask

  task automatic run(input logic [31:0] ins,
                     input logic clr_wb,
                     output logic [15:0] ea,
                     output logic [15:0] eb,
                     output int low,
                     output logic [15:0] rdo);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    check("rdy_wait", 32'(n < 20), 32'd1);
    in_valid = 1'b1;
    in_instr = ins;
    tick;
    in_valid = 1'b0;
    low = in_ready ? 0 : 1;
    tick;
    ea = alu_a;
    eb = alu_b;
    if (!in_ready) low++;
    tick;
    if (!in_ready) low++;
    if (clr_wb) err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    rdo = rd_data;
  endtask

  logic [15:0] ea;
  logic [15:0] eb;
  logic [15:0] v;
  logic [15:0] rdo;
  int          low;

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    rd_addr  = '0;
    err_clr  = 1'b0;
    tick;
    tick;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_op", 32'(alu_opcode), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick;
    check("rdy_after_rst", 32'(in_ready), 32'd1);

    // T1: reset mid-EXE aborts an ADD_I to r1
    in_valid = 1'b1;
    in_instr = mk(6'd2, 4'd1, 4'd0, 13'h0007);
    tick;
    in_valid = 1'b0;
    tick;
    check("t1_exe_b", 32'(alu_b), 32'h0007);
    check("t1_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_b", 32'(alu_b), 32'h0);
    check("t1_rst_a", 32'(alu_a), 32'h0);
    check("t1_rst_op", 32'(alu_opcode), 32'h0);
    check("t1_rst_busy", 32'(busy), 32'd0);
    check("t1_rst_err", 32'(err), 32'd0);
    check("t1_rst_rdy", 32'(in_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 1; i < 16; i++) begin
      rdreg(4'(i), v);
      check($sformatf("t1_r%0d", i), 32'(v), 32'h0);
    end

    // T2: ADD_I r3 = r0 + 5
    run(mk(6'd2, 4'd3, 4'd0, 13'h0005), 1'b0, ea, eb, low, rdo);
    check("t2_b", 32'(eb), 32'h0005);
    check("t2_low", 32'(low), 32'd3);
    check("t2_rdy", 32'(in_ready), 32'd1);
    check("t2_nop", 32'(alu_opcode), 32'd0);
    check("t2_hold_b", 32'(alu_b), 32'h0005);
    rdreg(4'd3, v);
    check("t2_r3", 32'(v), 32'h0005);

    // T3: sign-extended immediate
    run(mk(6'd2, 4'd4, 4'd0, 13'h1FFF), 1'b0, ea, eb, low, rdo);
    check("t3_b", 32'(eb), 32'hFFFF);
    rdreg(4'd4, v);
    check("t3_r4", 32'(v), 32'hFFFF);

    // T4: XOR r5 = r3 ^ r4
    run(mk(6'd19, 4'd5, 4'd3, {4'd4, 9'd0}), 1'b0,
        ea, eb, low, rdo);
    check("t4_a", 32'(ea), 32'h0005);
    check("t4_b", 32'(eb), 32'hFFFF);
    rdreg(4'd5, v);
    check("t4_r5", 32'(v), 32'hFFFA);

    // T5: illegal opcode, clear, and set-beats-clear
    run(mk(6'd14, 4'd6, 4'd3, {4'd4, 9'd0}), 1'b0,
        ea, eb, low, rdo);
    check("t5_err", 32'(err), 32'd1);
    check("t5_low", 32'(low), 32'd3);
    rdreg(4'd6, v);
    check("t5_r6", 32'(v), 32'h0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("t5_clr", 32'(err), 32'd0);
    run(mk(6'd14, 4'd6, 4'd3, {4'd4, 9'd0}), 1'b1,
        ea, eb, low, rdo);
    check("t5_setwins", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("t5_clr2", 32'(err), 32'd0);

    // T6: r0 write dropped, then read/write race on r3
    run(mk(6'd2, 4'd0, 4'd0, 13'h0005), 1'b0, ea, eb, low, rdo);
    check("t6_err", 32'(err), 32'd0);
    rdreg(4'd0, v);
    check("t6_r0", 32'(v), 32'h0);
    rd_addr = 4'd3;
    run(mk(6'd2, 4'd3, 4'd0, 13'h0009), 1'b0, ea, eb, low, rdo);
    check("t6_race_old", 32'(rdo), 32'h0005);
    tick;
    check("t6_race_new", 32'(rd_data), 32'h0009);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
